// File: rtl/au_dispatch_pkg.sv
// Shared architecture constants, opcode values and dispatcher state encoding
// for the arithmetic-unit dispatch slice.
package au_dispatch_pkg;

  localparam int ARCH_DATA_WIDTH   = 16;
  localparam int ARCH_OPCODE_WIDTH = 3;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MULT = 3'd3,
    OP_DIV  = 3'd4
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4
  } state_e;

endpackage

// File: rtl/au_dispatch_if.sv
// Instruction handshake channel into the dispatcher: the producer drives
// valid and the instruction fields, and the dispatcher answers with ready.
interface au_dispatch_if #(
  parameter int OPCODE_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 3
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [OPCODE_WIDTH-1:0]   instr_opcode;
  logic [REG_ADDR_WIDTH-1:0] instr_rd;
  logic [REG_ADDR_WIDTH-1:0] instr_rs1;
  logic [REG_ADDR_WIDTH-1:0] instr_rs2;

  modport master (
    output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
    output instr_ready
  );
endinterface

// File: rtl/au_regfile.sv
// Register file: two async source reads, an async debug read, a preload
// write port and a writeback port that wins when both hit one address.
module au_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

  // NOTE: this array is small and must read as zero after reset, so it is
  // built from flops with a reset loop rather than an unreset RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (ld_en) mem_q[ld_addr] <= ld_data;
      // Last non-blocking write to the same entry wins: writeback beats preload.
      if (wb_en) mem_q[wb_addr] <= wb_data;
    end
  end

endmodule

// File: rtl/au_dispatch.sv
// Dispatcher: accepts one instruction, reads operands, issues it to an
// external arithmetic unit, waits AU_WAIT cycles and writes the result back.
module au_dispatch
  import au_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH     = ARCH_DATA_WIDTH,
  parameter int OPCODE_WIDTH   = ARCH_OPCODE_WIDTH,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int AU_WAIT        = 1
) (
  input  logic                      Global_clk,
  input  logic                      Global_rst_n,
  au_dispatch_if.slave              instr,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      AU_op_enable,
  output logic [OPCODE_WIDTH-1:0]   Mode,
  output logic [DATA_WIDTH-1:0]     AU_in_1,
  output logic [DATA_WIDTH-1:0]     AU_in_2,
  input  logic [DATA_WIDTH-1:0]     AU_out,
  output logic                      done,
  output logic                      err_div0,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data
);
  localparam int WAIT_W = (AU_WAIT > 1) ? $clog2(AU_WAIT) : 1;

  state_e                    state_q;
  logic [OPCODE_WIDTH-1:0]   opcode_q, mode_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0]     in1_q, in2_q, rs1_data, rs2_data;
  logic [WAIT_W-1:0]         wait_q;
  logic                      en_q, done_q, err_q, skip_q, div0_q;
  logic                      is_nop, is_div0, wb_en;

  assign is_nop  = (opcode_q == OPCODE_WIDTH'(OP_NOP));
  // Sign-magnitude: 0x8000 is negative zero, so only the magnitude decides.
  assign is_div0 = (opcode_q == OPCODE_WIDTH'(OP_DIV)) &&
                   (rs2_data[DATA_WIDTH-2:0] == '0);
  assign wb_en   = (state_q == S_WB) && !skip_q;

  assign instr.instr_ready = (state_q == S_IDLE);
  assign AU_op_enable      = en_q;
  assign Mode              = mode_q;
  assign AU_in_1           = in1_q;
  assign AU_in_2           = in2_q;
  assign done              = done_q;
  assign err_div0          = err_q;

  au_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clk      (Global_clk),
    .rst_n    (Global_rst_n),
    .ra_addr  (rs1_q),
    .ra_data  (rs1_data),
    .rb_addr  (rs2_q),
    .rb_data  (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .ld_en    (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (AU_out)
  );

  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge Global_clk) begin
    if (!Global_rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      mode_q   <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      wait_q   <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      skip_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (instr.instr_valid) begin
            opcode_q <= instr.instr_opcode;
            rd_q     <= instr.instr_rd;
            rs1_q    <= instr.instr_rs1;
            rs2_q    <= instr.instr_rs2;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          mode_q <= opcode_q;
          in1_q  <= rs1_data;
          in2_q  <= rs2_data;
          skip_q <= is_nop || is_div0;
          div0_q <= is_div0;
          if (is_nop || is_div0) begin
            state_q <= S_WB;
          end else begin
            en_q    <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_W'(AU_WAIT - 1)) state_q <= S_WB;
          else                                wait_q  <= wait_q + 1'b1;
        end
        S_WB: begin
          done_q  <= 1'b1;
          err_q   <= div0_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_au_dispatch.sv
// Directed bench for au_dispatch with a sign-magnitude arithmetic-unit model
// driving AU_out from the issued operands.
module tb_au_dispatch;
  import au_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic        AU_op_enable;
  logic [2:0]  Mode;
  logic [15:0] AU_in_1, AU_in_2, AU_out;
  logic        done, err_div0;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  au_dispatch_if ifc ();

  au_dispatch dut (
    .Global_clk   (clk),
    .Global_rst_n (rst_n),
    .instr        (ifc),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .AU_op_enable (AU_op_enable),
    .Mode         (Mode),
    .AU_in_1      (AU_in_1),
    .AU_in_2      (AU_in_2),
    .AU_out       (AU_out),
    .done         (done),
    .err_div0     (err_div0),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] au_model(logic [2:0] m, logic [15:0] a, logic [15:0] b);
    int x, y, r;
    x = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    y = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    case (m)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_MULT: r = x * y;
      OP_DIV:  r = (y == 0) ? 0 : x / y;
      default: r = 0;
    endcase
    return (r < 0) ? {1'b1, 15'(-r)} : {1'b0, 15'(r)};
  endfunction

  assign AU_out = au_model(Mode, AU_in_1, AU_in_2);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic dbg_check(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Issue one instruction and track it to done; optionally preload at the
  // cycle index ld_cyc counted from the accept edge (0 = READ cycle).
  task automatic run_instr(input string tag, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2,
                           input int exp_lat, input logic exp_err, input int exp_en,
                           input int ld_cyc, input logic [2:0] la, input logic [15:0] ldd);
    int         lat = 0, en_cnt = 0, ready_bad = 0;
    logic       err_seen = 1'b0;
    logic [2:0] en_mode = '0;
    @(negedge clk);
    check({tag, "_ready_idle"}, ifc.instr_ready, 1'b1);
    ifc.instr_valid = 1'b1; ifc.instr_opcode = op;
    ifc.instr_rd = rd; ifc.instr_rs1 = rs1; ifc.instr_rs2 = rs2;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    if (ld_cyc == 0) begin ld_valid = 1'b1; ld_addr = la; ld_data = ldd; end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      ld_valid = 1'b0;
      if (AU_op_enable) begin en_cnt++; en_mode = Mode; end
      if (done) begin lat = cyc; err_seen = err_div0; break; end
      if (ifc.instr_ready) ready_bad++;
      if (cyc == ld_cyc) begin ld_valid = 1'b1; ld_addr = la; ld_data = ldd; end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_enables"}, en_cnt, exp_en);
    check({tag, "_err_div0"}, err_seen, exp_err);
    check({tag, "_mode_at_done"}, Mode, op);
    check({tag, "_ready_busy"}, ready_bad, 0);
    if (exp_en > 0) check({tag, "_mode_at_issue"}, en_mode, op);
  endtask

  initial begin
    int busy, done_cnt;
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    ifc.instr_valid = 1'b0; ifc.instr_opcode = '0;
    ifc.instr_rd = '0; ifc.instr_rs1 = '0; ifc.instr_rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_ready", ifc.instr_ready, 1'b1);
    check("rst_enable", AU_op_enable, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mode", Mode, 3'd0);
    check("rst_in1", AU_in_1, 16'h0);
    dbg_check("rst_r1", 3'd1, 16'h0);

    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h8003);
    preload(3'd6, 16'h8000);
    dbg_check("pre_r1", 3'd1, 16'h0005);
    dbg_check("pre_r2", 3'd2, 16'h8003);

    run_instr("add", OP_ADD, 3'd3, 3'd1, 3'd2, 4, 1'b0, 1, -1, 3'd0, 16'h0);
    dbg_check("add_r3", 3'd3, 16'h0002);
    run_instr("sub", OP_SUB, 3'd4, 3'd1, 3'd2, 4, 1'b0, 1, -1, 3'd0, 16'h0);
    dbg_check("sub_r4", 3'd4, 16'h0008);
    run_instr("mult", OP_MULT, 3'd5, 3'd1, 3'd2, 4, 1'b0, 1, -1, 3'd0, 16'h0);
    dbg_check("mult_r5", 3'd5, 16'h800F);
    run_instr("div0", OP_DIV, 3'd7, 3'd1, 3'd6, 2, 1'b1, 0, -1, 3'd0, 16'h0);
    dbg_check("div0_r7", 3'd7, 16'h0000);
    run_instr("div", OP_DIV, 3'd7, 3'd1, 3'd2, 4, 1'b0, 1, -1, 3'd0, 16'h0);
    dbg_check("div_r7", 3'd7, 16'h8001);
    run_instr("nop", OP_NOP, 3'd1, 3'd2, 3'd2, 2, 1'b0, 0, -1, 3'd0, 16'h0);
    dbg_check("nop_r1", 3'd1, 16'h0005);

    // Back-to-back with valid held: ADD r1=r1+r1 then SUB r2=r1-r2.
    @(negedge clk);
    ifc.instr_valid = 1'b1; ifc.instr_opcode = OP_ADD;
    ifc.instr_rd = 3'd1; ifc.instr_rs1 = 3'd1; ifc.instr_rs2 = 3'd1;
    @(posedge clk); #1;
    ifc.instr_opcode = OP_SUB;
    ifc.instr_rd = 3'd2; ifc.instr_rs1 = 3'd1; ifc.instr_rs2 = 3'd2;
    busy = 0;
    for (int c = 0; c < 20; c++) begin
      if (ifc.instr_ready) break;
      busy++;
      @(posedge clk); #1;
    end
    check("b2b_busy_cycles", busy, 4);
    check("b2b_first_done", done, 1'b1);
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_second_enable", AU_op_enable, 1'b1);
    check("b2b_second_in1", AU_in_1, 16'h000A);
    check("b2b_second_in2", AU_in_2, 16'h8003);
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check("b2b_second_done", done, 1'b1);
    dbg_check("b2b_r1", 3'd1, 16'h000A);
    dbg_check("b2b_r2", 3'd2, 16'h000D);
    @(posedge clk); #1;
    check("b2b_no_dup", AU_op_enable, 1'b0);

    // Preload colliding with writeback to r3 in the WB cycle: WB wins.
    run_instr("wbcol", OP_ADD, 3'd3, 3'd1, 3'd2, 4, 1'b0, 1, 3, 3'd3, 16'h1234);
    dbg_check("wbcol_r3", 3'd3, 16'h0017);
    // Preload to another address in the WB cycle: both land.
    run_instr("wbpar", OP_SUB, 3'd5, 3'd2, 3'd1, 4, 1'b0, 1, 3, 3'd6, 16'h0042);
    dbg_check("wbpar_r5", 3'd5, 16'h0003);
    dbg_check("wbpar_r6", 3'd6, 16'h0042);
    // Preload of a source during READ: the old value is used.
    run_instr("rdcol", OP_ADD, 3'd4, 3'd1, 3'd1, 4, 1'b0, 1, 0, 3'd1, 16'h0100);
    dbg_check("rdcol_r4", 3'd4, 16'h0014);
    dbg_check("rdcol_r1", 3'd1, 16'h0100);

    // Reset asserted during WAIT aborts the instruction.
    @(negedge clk);
    ifc.instr_valid = 1'b1; ifc.instr_opcode = OP_ADD;
    ifc.instr_rd = 3'd0; ifc.instr_rs1 = 3'd1; ifc.instr_rs2 = 3'd2;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_issue_enable", AU_op_enable, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw_enable", AU_op_enable, 1'b0);
    check("rstw_done", done, 1'b0);
    check("rstw_err", err_div0, 1'b0);
    check("rstw_mode", Mode, 3'd0);
    check("rstw_in1", AU_in_1, 16'h0);
    check("rstw_in2", AU_in_2, 16'h0);
    rst_n = 1'b1;
    check("rstw_ready", ifc.instr_ready, 1'b1);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("rstw_no_done", done_cnt, 0);
    dbg_check("rstw_r0", 3'd0, 16'h0000);
    dbg_check("rstw_r1", 3'd1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
